// File: rtl/cache_pkg.sv
// Shared geometry and state encoding for the 4-way read-only cache.
package cache_pkg;
    localparam int IDX_W = 4;
    localparam int OFF_W = 2;
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam int WAYS  = 4;
    localparam int WAY_W = 2;
    localparam int SETS  = 1 << IDX_W;
    localparam int WORDS = 1 << OFF_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        INSTALL = 2'd2
    } state_e;
endpackage

// File: rtl/way_compare.sv
// Per-way tag comparators with valid gating; also encodes the hit way for the data mux.
module way_compare
    import cache_pkg::*;
(
    input  logic [WAYS-1:0]            way_valid,
    input  logic [WAYS-1:0][TAG_W-1:0] way_tag,
    input  logic [TAG_W-1:0]           addr_tag,
    output logic [WAYS-1:0]            eq,
    output logic                       hit,
    output logic [WAY_W-1:0]           sel
);
    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign eq[w] = way_valid[w] && (way_tag[w] == addr_tag);
    end

    assign hit = |eq;

    // eq is one-hot on a hit, so a priority encode is an exact one-hot decode
    always_comb begin
        sel = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (eq[i]) sel = WAY_W'(i);
        end
    end
endmodule

// File: rtl/cache_way_ctrl.sv
// 4-way set-associative read-only cache: lookup, refill burst and install,
// with flop-based tag/data/valid arrays.
module cache_way_ctrl
    import cache_pkg::*;
(
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Req,
    input  logic [31:0]      Addr,
    input  logic             Flush,
    output logic [31:0]      RData,
    output logic             Stall,
    output logic [WAYS-1:0]  RepValid,
    output logic [WAYS-1:0]  RepEq,
    output logic             RepInit,
    input  logic [WAY_W-1:0] RepS,
    output logic             MemReq,
    output logic [31:0]      MemAddr,
    input  logic             MemReady,
    input  logic [31:0]      MemRData
);
    state_e                                     state_q, state_d;
    logic [OFF_W-1:0]                           cnt_q, cnt_d;
    logic [WAY_W-1:0]                           vic_way_q, vic_way_d;
    logic [TAG_W-1:0]                           vic_tag_q, vic_tag_d;
    logic [IDX_W-1:0]                           vic_idx_q, vic_idx_d;
    logic [WAYS-1:0][SETS-1:0]                  valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0][TAG_W-1:0]       tag_q, tag_d;
    logic [WAYS-1:0][SETS-1:0][WORDS-1:0][31:0] data_q, data_d;

    logic [TAG_W-1:0]            a_tag;
    logic [IDX_W-1:0]            a_idx;
    logic [OFF_W-1:0]            a_off;
    logic [WAYS-1:0]             set_valid;
    logic [WAYS-1:0][TAG_W-1:0]  set_tag;
    logic                        hit;
    logic [WAY_W-1:0]            hit_sel;
    logic                        rep_init;
    logic                        addr_unused;

    assign a_tag       = Addr[31 -: TAG_W];
    assign a_idx       = Addr[OFF_W+2 +: IDX_W];
    assign a_off       = Addr[2 +: OFF_W];
    assign addr_unused = ^Addr[1:0];

    always_comb begin
        set_valid = '0;
        set_tag   = '0;
        for (int w = 0; w < WAYS; w++) begin
            set_valid[w] = valid_q[w][a_idx];
            set_tag[w]   = tag_q[w][a_idx];
        end
    end

    way_compare u_cmp (
        .way_valid (set_valid),
        .way_tag   (set_tag),
        .addr_tag  (a_tag),
        .eq        (RepEq),
        .hit       (hit),
        .sel       (hit_sel)
    );

    assign RepValid = set_valid;
    assign RData    = data_q[hit_sel][a_idx][a_off];
    assign MemAddr  = {vic_tag_q, vic_idx_q, cnt_q, 2'b00};
    assign RepInit  = rep_init && !Reset;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vic_way_d = vic_way_q;
        vic_tag_d = vic_tag_q;
        vic_idx_d = vic_idx_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        Stall     = 1'b0;
        rep_init  = 1'b0;
        MemReq    = 1'b0;
        case (state_q)
            IDLE: begin
                if (Flush) begin
                    Stall   = 1'b1;
                    valid_d = '0;
                end else if (Req) begin
                    rep_init = 1'b1;
                    if (!hit) begin
                        Stall     = 1'b1;
                        state_d   = REFILL;
                        vic_way_d = RepS;
                        vic_tag_d = a_tag;
                        vic_idx_d = a_idx;
                        cnt_d     = '0;
                        // victim line is being overwritten; keep it invalid until install
                        valid_d[RepS][a_idx] = 1'b0;
                    end
                end
            end
            REFILL: begin
                Stall  = 1'b1;
                MemReq = 1'b1;
                if (MemReady) begin
                    data_d[vic_way_q][vic_idx_q][cnt_q] = MemRData;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS - 1)) state_d = INSTALL;
                end
            end
            INSTALL: begin
                Stall                       = 1'b1;
                tag_d[vic_way_q][vic_idx_q]   = vic_tag_q;
                valid_d[vic_way_q][vic_idx_q] = 1'b1;
                state_d                     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge CLK) begin
        vic_way_q <= vic_way_d;
        vic_tag_q <= vic_tag_d;
        vic_idx_q <= vic_idx_d;
        tag_q     <= tag_d;
        data_q    <= data_d;
    end

    a_eq_onehot: assert property (@(posedge CLK) disable iff (Reset) $onehot0(RepEq));
endmodule
